// File: rtl/prog_loader_if.sv
// Byte stream into the loader and the instruction-memory write port out of it.
// master = stream source and memory observer, slave = the loader.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot loader: length header, little-endian words, XOR checksum; each word is written 1 cycle after its 4th byte.
// Never stalls mid-image; byte_ready drops only in DONE/ERROR until a reload.
module prog_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      bus,
  input  logic              reload,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  logic            xfer;
  logic [ADDR_W:0] wcnt_inc;

  assign bus.byte_ready = (state_q == LEN0) || (state_q == LEN1) ||
                          (state_q == DATA) || (state_q == CSUM);
  assign xfer     = bus.byte_valid && bus.byte_ready;
  assign wcnt_inc = wcnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    wcnt_d     = wcnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    run_d      = run_q;
    err_d      = err_q;

    case (state_q)
      LEN0: if (xfer) begin
        len_d   = {len_q[15:8], bus.byte_data};
        state_d = LEN1;
      end
      LEN1: if (xfer) begin
        len_d = {bus.byte_data, len_q[7:0]};
        if ({1'b0, len_d} > MAX_LEN) begin
          state_d = ERROR;
          err_d   = 1'b1;
        end else if (len_d == 16'd0) begin
          state_d = CSUM;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        // Shifting in from the top leaves byte 0 in [7:0] after four bytes.
        word_d     = {bus.byte_data, word_q[31:8]};
        csum_d     = csum_q ^ bus.byte_data;
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = word_d;
          wcnt_d  = wcnt_inc;
          if (17'(wcnt_inc) == {1'b0, len_q}) state_d = CSUM;
        end
      end
      CSUM: if (xfer) begin
        if (bus.byte_data == csum_q) begin
          state_d = DONE;
          run_d   = 1'b1;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
        end
      end
      DONE, ERROR: if (reload) begin
        state_d    = LEN0;
        run_d      = 1'b0;
        err_d      = 1'b0;
        wcnt_d     = '0;
        csum_d     = '0;
        byte_idx_d = '0;
      end
      default: state_d = LEN0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LEN0;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      wcnt_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      wcnt_q     <= wcnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_run        = run_q;
  assign load_err       = err_q;
  assign words_loaded   = wcnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed streams for prog_loader; expected memory writes go through a scoreboard queue.
module tb_prog_loader;
  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            reload = 1'b0;
  logic            cpu_run, load_err;
  logic [ADDR_W:0] words_loaded;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .reload       (reload),
    .cpu_run      (cpu_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory-write monitor, independent of the stimulus process.
  always @(negedge clk) begin
    if (rst && bus.imem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=0x%0h wdata=0x%0h, no write expected",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e) begin
          bad++;
          $display("FAIL imem_write: got addr=0x%0h wdata=0x%0h expected addr=0x%0h wdata=0x%0h",
                   bus.imem_addr, bus.imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present one byte and hold it until transferred; returns 1ns after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within 20 cycles", b);
    end
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    chk({tag, "_reload_cpu_run"}, 32'(cpu_run), 32'd0);
    chk({tag, "_reload_err"}, 32'(load_err), 32'd0);
    chk({tag, "_reload_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_reload_ready"}, 32'(bus.byte_ready), 32'd1);
  endtask

  task automatic drained(input string tag);
    idle(3);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0] basic_img[7];
  logic [7:0] one_img[6];

  initial begin
    basic_img = '{8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00};
    one_img   = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values
    #12;
    chk("rst_ready", 32'(bus.byte_ready), 32'd1);
    chk("rst_we", 32'(bus.imem_we), 32'd0);
    chk("rst_cpu_run", 32'(cpu_run), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk) rst = 1'b1;

    // Basic load, back-to-back bytes
    expect_write(8'd0, 32'h2000_0013);
    expect_write(8'd1, 32'h0800_0008);
    send(8'h02); send(8'h00);
    foreach (basic_img[i]) send(basic_img[i]);
    send(8'h08);
    @(negedge clk);
    chk("basic_run_before_csum", 32'(cpu_run), 32'd0);
    send(8'h33);
    chk("basic_cpu_run", 32'(cpu_run), 32'd1);
    chk("basic_words", 32'(words_loaded), 32'd2);
    chk("basic_err", 32'(load_err), 32'd0);
    chk("basic_ready_done", 32'(bus.byte_ready), 32'd0);
    drained("basic");

    // Reload then a one-word image
    do_reload("one");
    expect_write(8'd0, 32'hDDCC_BBAA);
    foreach (one_img[i]) send(one_img[i]);
    send(8'h00);
    chk("one_cpu_run", 32'(cpu_run), 32'd1);
    chk("one_words", 32'(words_loaded), 32'd1);
    drained("one");

    // Bad checksum
    do_reload("badcs");
    expect_write(8'd0, 32'h2000_0013);
    expect_write(8'd1, 32'h0800_0008);
    send(8'h02); send(8'h00);
    foreach (basic_img[i]) send(basic_img[i]);
    send(8'h08);
    send(8'h34);
    chk("badcs_err", 32'(load_err), 32'd1);
    chk("badcs_cpu_run", 32'(cpu_run), 32'd0);
    chk("badcs_ready", 32'(bus.byte_ready), 32'd0);
    drained("badcs");

    // Oversize header, then bytes that must not be consumed
    do_reload("big");
    send(8'h01); send(8'h01);
    chk("big_err", 32'(load_err), 32'd1);
    chk("big_ready", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    idle(5);
    chk("big_ready_held", 32'(bus.byte_ready), 32'd0);
    chk("big_words", 32'(words_loaded), 32'd0);
    bus.byte_valid = 1'b0;
    drained("big");

    // Zero-length image
    do_reload("zero");
    send(8'h00); send(8'h00); send(8'h00);
    chk("zero_cpu_run", 32'(cpu_run), 32'd1);
    chk("zero_words", 32'(words_loaded), 32'd0);
    chk("zero_err", 32'(load_err), 32'd0);
    drained("zero");

    // Throttled source: idle cycle between every byte
    do_reload("thr");
    expect_write(8'd0, 32'h2000_0013);
    expect_write(8'd1, 32'h0800_0008);
    send(8'h02); idle(1); send(8'h00); idle(1);
    foreach (basic_img[i]) begin send(basic_img[i]); idle(1); end
    send(8'h08); idle(1);
    chk("thr_run_before_csum", 32'(cpu_run), 32'd0);
    send(8'h33);
    chk("thr_cpu_run", 32'(cpu_run), 32'd1);
    chk("thr_words", 32'(words_loaded), 32'd2);
    drained("thr");

    // Reset mid-load after six bytes
    do_reload("mid");
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    rst = 1'b0;
    #1;
    chk("mid_we", 32'(bus.imem_we), 32'd0);
    chk("mid_words", 32'(words_loaded), 32'd0);
    chk("mid_ready", 32'(bus.byte_ready), 32'd1);
    chk("mid_cpu_run", 32'(cpu_run), 32'd0);
    chk("mid_addr", 32'(bus.imem_addr), 32'd0);
    idle(2);
    @(negedge clk) rst = 1'b1;
    drained("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader upstream of the single-cycle MIPS machine.
- Accepts a byte stream (valid/ready) carrying a length header, instruction words and a checksum.
- Packs the bytes into 32-bit words and writes them to the instruction memory write port at consecutive word addresses.
- Releases the core through cpu_run once the image is verified; the core's PC advances by 1 per instruction, so addresses are word indices.

Parameters:
- ADDR_W, 8, instruction-memory word address width.
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
- reload  in  1  single-cycle request to restart loading; honoured only in DONE or ERROR.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_run  out  1  1 = core may run (drives core reset release); 0 holds core in reset.
- load_err  out  1  sticky error flag.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LEN0; all outputs 0 except byte_ready=1 (combinational from state).
  - word count, byte index and checksum cleared.
- States: LEN0, LEN1, DATA, CSUM, DONE, ERROR. byte_ready=1 in LEN0/LEN1/DATA/CSUM, 0 in DONE/ERROR.
- LEN0: on transfer, latch len[7:0] → LEN1.
- LEN1: on transfer, latch len[15:8], then:
  - len > MAX_WORDS → ERROR.
  - len == 0 → CSUM.
  - otherwise → DATA.
- DATA:
  - Bytes are little-endian within a word: byte 0 → [7:0] ... byte 3 → [31:24].
  - Checksum accumulates the XOR of every data byte (header bytes excluded).
  - On the 4th byte's transfer: next cycle imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=words_loaded (before increment).
  - words_loaded increments in that same cycle.
  - When the word just completed is word len-1, transition → CSUM.
  - No stall: byte_ready stays 1 while the write strobe is pending.
- CSUM: on transfer:
  - byte == accumulated XOR → DONE; cpu_run=1 from the next cycle.
  - Mismatch → ERROR.
- DONE: cpu_run=1 held; load_err=0.
- ERROR: load_err=1 held; cpu_run=0.
- reload in DONE or ERROR:
  - next cycle state=LEN0; cpu_run=0, load_err=0, words_loaded=0, checksum=0.
  - Instruction memory contents are not cleared.
- reload in any other state is ignored.
- Idle cycles (byte_valid=0) never alter state; there is no timeout.
- Reset mid-load: immediate return to reset values. Partial words are discarded and never written.
- imem_addr and imem_wdata hold their last value when imem_we=0.
- A stream byte arriving while byte_ready=0 is not consumed; the source must hold it.

Test Plan:
- Basic load:
  - Stimulus: stream 02 00, 13 00 00 20, 08 00 00 08, checksum 0x33.
  - Required response: imem_we pulses with addr 0 wdata 0x20000013, then addr 1 wdata 0x08000008; words_loaded=2; cpu_run=1 one cycle after the checksum byte; load_err=0.
- Bad checksum:
  - Stimulus: same image with checksum 0x34.
  - Required response: two writes still occur; load_err=1; cpu_run=0; byte_ready=0 afterwards.
- Oversize header:
  - Stimulus: MAX_WORDS=256, header 01 01 (257).
  - Required response: ERROR right after LEN1; no imem_we; subsequent bytes not accepted.
- Zero-length image:
  - Stimulus: 00 00 00.
  - Required response: no writes; cpu_run=1; words_loaded=0.
- Throttled source and reset mid-load:
  - Stimulus: byte_valid toggling every other cycle → identical writes to the basic load. Then rst=0 after 6 bytes of a new load.
  - Required response: outputs 0 immediately; no write of the partial word.
- Reload:
  - Stimulus: from DONE pulse reload, then send a 1-word image 01 00 AA BB CC DD, checksum 0x00.
  - Required response: cpu_run drops the cycle after reload; write addr 0 wdata 0xDDCCBBAA; cpu_run=1 again.
